// File: rtl/mcpu_pkg.sv
// Shared definitions for the multicycle core: opcodes, FSM encoding and
// instruction field positions.
package mcpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LI   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JNZ  = 4'hC;
  localparam logic [3:0] OP_CMP  = 4'hD;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // Word layout, MSB first: op[4] | dst | src0 | src1 | imm
  function automatic int instr_w(input int reg_aw, input int data_w);
    return 4 + 3 * reg_aw + data_w;
  endfunction

  function automatic int op_lsb(input int reg_aw, input int data_w);
    return 3 * reg_aw + data_w;
  endfunction

  function automatic int dst_lsb(input int reg_aw, input int data_w);
    return 2 * reg_aw + data_w;
  endfunction

  function automatic int src0_lsb(input int reg_aw, input int data_w);
    return reg_aw + data_w;
  endfunction

  function automatic int src1_lsb(input int reg_aw, input int data_w);
    return (reg_aw > 0) ? data_w : data_w;
  endfunction

endpackage

// File: rtl/mcpu_alu.sv
// Combinational ALU; CMP shares the subtractor so zero means src0 == src1.
module mcpu_alu
  import mcpu_pkg::*;
#(
  parameter int DATA_W = 28
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD, OP_ADDI: result = a + b;
      OP_SUB, OP_CMP:  result = a - b;
      OP_AND:          result = a & b;
      OP_OR:           result = a | b;
      OP_XOR:          result = a ^ b;
      default:         result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mcpu_core.sv
// Multicycle CPU core: PC, register file, ALU, zero flag and control FSM, with
// instruction and data memories behind req/ack handshakes.
//
// state | meaning
// BOOT  | first cycle after reset release, no request
// FETCH | imem_req high until imem_ack latches the instruction
// EXEC  | decode, ALU, writeback; LD/ST latch address/data for MEM
// MEM   | dmem_req high with stable addr/we/wdata until dmem_ack
// HALT  | absorbing, no requests; only reset leaves
module mcpu_core
  import mcpu_pkg::*;
#(
  parameter int              DATA_W   = 28,
  parameter int              REG_N    = 16,
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  localparam int             REG_AW   = $clog2(REG_N),
  localparam int             INSTR_W  = 4 + 3 * REG_AW + DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic [REG_AW-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data,
  output logic               zf,
  output logic               halted,
  output logic [31:0]        instret
);

  localparam int OP_LSB   = op_lsb(REG_AW, DATA_W);
  localparam int DST_LSB  = dst_lsb(REG_AW, DATA_W);
  localparam int SRC0_LSB = src0_lsb(REG_AW, DATA_W);
  localparam int SRC1_LSB = src1_lsb(REG_AW, DATA_W);

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d, pc_inc, jmp_target;
  logic [INSTR_W-1:0]  ir_q;
  logic [DATA_W-1:0]   regs [REG_N];
  logic                zf_q, zf_d;
  logic [31:0]         instret_q;
  logic [DATA_W-1:0]   maddr_q, mwdata_q;
  logic                mwe_q;

  logic [3:0]          op;
  logic [REG_AW-1:0]   dst, src0, src1;
  logic [DATA_W-1:0]   imm, a_val, b_val, alu_b, alu_res;
  logic                alu_zero;

  logic                ir_ld, mem_ld, retire, rf_we;
  logic [DATA_W-1:0]   rf_wdata;

  assign op         = ir_q[OP_LSB +: 4];
  assign dst        = ir_q[DST_LSB +: REG_AW];
  assign src0       = ir_q[SRC0_LSB +: REG_AW];
  assign src1       = ir_q[SRC1_LSB +: REG_AW];
  assign imm        = ir_q[DATA_W-1:0];
  assign a_val      = regs[src0];
  assign b_val      = regs[src1];
  assign alu_b      = (op == OP_ADDI) ? imm : b_val;
  assign pc_inc     = pc_q + PC_W'(1);
  assign jmp_target = imm[PC_W-1:0];

  mcpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (a_val),
    .b      (alu_b),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    zf_d     = zf_q;
    ir_ld    = 1'b0;
    mem_ld   = 1'b0;
    retire   = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          ir_ld   = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_NOP: ;
          OP_LI: begin
            rf_we    = 1'b1;
            rf_wdata = imm;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
            rf_we = 1'b1;
            zf_d  = alu_zero;
          end
          OP_CMP: zf_d = alu_zero;
          // Memory ops retire on the ack, not here
          OP_LD, OP_ST: begin
            retire  = 1'b0;
            mem_ld  = 1'b1;
            pc_d    = pc_q;
            state_d = ST_MEM;
          end
          OP_JMP: pc_d = jmp_target;
          OP_JZ:  pc_d = zf_q ? jmp_target : pc_inc;
          OP_JNZ: pc_d = zf_q ? pc_inc : jmp_target;
          default: begin
            pc_d    = pc_q;
            state_d = ST_HALT;
          end
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          rf_we    = ~mwe_q;
          rf_wdata = dmem_rdata;
          pc_d     = pc_inc;
          retire   = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      zf_q      <= 1'b0;
      instret_q <= '0;
      ir_q      <= '0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
      mwe_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      zf_q    <= zf_d;
      if (retire) instret_q <= instret_q + 32'd1;
      if (ir_ld)  ir_q      <= imem_rdata;
      if (mem_ld) begin
        maddr_q  <= b_val;
        mwdata_q <= a_val;
        mwe_q    <= (op == OP_ST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (rf_we) begin
      regs[dst] <= rf_wdata;
    end
  end

  // Requests decode straight from state so an async reset drops them at once
  assign imem_req   = (state_q == ST_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == ST_MEM);
  assign dmem_we    = dmem_req & mwe_q;
  assign dmem_addr  = maddr_q;
  assign dmem_wdata = mwdata_q;
  assign dbg_data   = regs[dbg_sel];
  assign zf         = zf_q;
  assign halted     = (state_q == ST_HALT);
  assign instret    = instret_q;

endmodule

// File: tb/tb_mcpu_core.sv
// Scoreboard bench for mcpu_core: stimulus queues expectations, a negedge
// monitor compares them against the core and its memory handshakes.
module tb_mcpu_core;
  localparam int DATA_W = 28;
  localparam int REG_N = 16;
  localparam int PC_W = 12;
  localparam int REG_AW = 4;
  localparam int INSTR_W = 44;

  localparam int K_REG = 0, K_ZF = 1, K_HALT = 2, K_INSTRET = 3;
  localparam int K_PC = 4, K_IREQ = 5, K_DREQ = 6, K_VAL = 7;

  typedef struct {
    int          kind;
    logic [63:0] exp;
    logic [63:0] act;
    string       name;
  } item_t;

  typedef struct {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dtx_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               imem_req, imem_ack;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dmem_req, dmem_we, dmem_ack;
  logic [DATA_W-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [REG_AW-1:0]  dbg_sel;
  logic [DATA_W-1:0]  dbg_data;
  logic               zf, halted;
  logic [31:0]        instret;

  logic [INSTR_W-1:0] imem [0:4095];
  logic [DATA_W-1:0]  dmem [0:255];
  int imem_wait, dmem_wait, icnt, dcnt;
  logic spur_i, spur_d, fchk_en;

  item_t sq[$];
  dtx_t  dq[$];
  logic [PC_W-1:0] fq[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mcpu_core #(.DATA_W(DATA_W), .REG_N(REG_N), .PC_W(PC_W), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .zf(zf), .halted(halted), .instret(instret)
  );

  // Wait-state memory models: ack after N cycles of held request
  assign imem_ack   = spur_i | (imem_req && icnt >= imem_wait);
  assign dmem_ack   = spur_d | (dmem_req && dcnt >= dmem_wait);
  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr[7:0]];

  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[7:0]] <= dmem_wdata;
  end

  // Monitor
  item_t it;
  dtx_t dt;
  logic [63:0] act;
  logic [PC_W-1:0] prev_iaddr, exp_f;
  logic [DATA_W-1:0] prev_daddr, prev_dwdata;
  logic prev_ireq = 1'b0, prev_iack = 1'b0, prev_dreq = 1'b0, prev_dack = 1'b0, prev_dwe;

  always @(negedge clk) begin
    while (sq.size() > 0) begin
      it = sq.pop_front();
      case (it.kind)
        K_REG:     act = 64'(dbg_data);
        K_ZF:      act = 64'(zf);
        K_HALT:    act = 64'(halted);
        K_INSTRET: act = 64'(instret);
        K_PC:      act = 64'(imem_addr);
        K_IREQ:    act = 64'(imem_req);
        K_DREQ:    act = 64'(dmem_req);
        default:   act = it.act;
      endcase
      checks++;
      if (act !== it.exp) begin
        failures++;
        $display("FAIL %s actual=0x%0h required=0x%0h", it.name, act, it.exp);
      end
    end
    if (imem_req && prev_ireq && !prev_iack) begin
      checks++;
      if (imem_addr !== prev_iaddr) begin
        failures++;
        $display("FAIL imem_addr_stable actual=0x%0h required=0x%0h", imem_addr, prev_iaddr);
      end
    end
    if (dmem_req && prev_dreq && !prev_dack) begin
      checks++;
      if ({dmem_we, dmem_addr, dmem_wdata} !== {prev_dwe, prev_daddr, prev_dwdata}) begin
        failures++;
        $display("FAIL dmem_stable actual=0x%0h required=0x%0h",
                 {dmem_we, dmem_addr, dmem_wdata}, {prev_dwe, prev_daddr, prev_dwdata});
      end
    end
    if (dmem_req && dmem_ack) begin
      checks++;
      if (dq.size() == 0) begin
        failures++;
        $display("FAIL dmem_unexpected actual=0x%0h required=none", dmem_addr);
      end else begin
        dt = dq.pop_front();
        if (dmem_we !== dt.we || dmem_addr !== dt.addr || (dt.we && dmem_wdata !== dt.wdata)) begin
          failures++;
          $display("FAIL dmem_txn actual=we%0b/0x%0h/0x%0h required=we%0b/0x%0h/0x%0h",
                   dmem_we, dmem_addr, dmem_wdata, dt.we, dt.addr, dt.wdata);
        end
      end
    end
    if (fchk_en && imem_req && imem_ack) begin
      checks++;
      exp_f = (fq.size() > 0) ? fq.pop_front() : 12'hEEE;
      if (imem_addr !== exp_f) begin
        failures++;
        $display("FAIL fetch_addr actual=0x%0h required=0x%0h", imem_addr, exp_f);
      end
    end
    prev_ireq = imem_req; prev_iack = imem_ack; prev_iaddr = imem_addr;
    prev_dreq = dmem_req; prev_dack = dmem_ack; prev_dwe = dmem_we;
    prev_daddr = dmem_addr; prev_dwdata = dmem_wdata;
  end

  function automatic logic [INSTR_W-1:0] ins(int op, int d, int a, int b, int imm);
    return {4'(op), 4'(d), 4'(a), 4'(b), 28'(imm)};
  endfunction

  task automatic put(int a, logic [INSTR_W-1:0] w);
    imem[a[11:0]] = w;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 4096; i++) imem[i] = '0;
  endtask

  task automatic push(int kind, logic [63:0] exp, logic [63:0] actv, string name);
    item_t n;
    n.kind = kind; n.exp = exp; n.act = actv; n.name = name;
    sq.push_back(n);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(int sel, logic [63:0] e, string name);
    dbg_sel = 4'(sel);
    push(K_REG, e, 64'd0, name);
    settle();
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    settle();
    settle();
  endtask

  // Releases reset just after an edge and counts edges until halted
  task automatic run(int maxc, output int n);
    rst_n = 1'b1;
    n = 0;
    while (n < maxc) begin
      @(posedge clk);
      n++;
      #1;
      if (halted) break;
    end
    push(K_HALT, 64'd1, 64'd0, "halted_reached");
  endtask

  task automatic check_prog1(int n, int exp_n, string tag);
    push(K_VAL, 64'(exp_n), 64'(n), {tag, "_cycles"});
    push(K_ZF, 64'd1, 64'd0, {tag, "_zf"});
    push(K_INSTRET, 64'd5, 64'd0, {tag, "_instret"});
    push(K_PC, 64'd6, 64'd0, {tag, "_pc"});
    settle();
    check_reg(1, 64'd5, {tag, "_r1"});
    check_reg(3, 64'd0, {tag, "_r3"});
    check_reg(4, 64'd0, {tag, "_r4"});
  endtask

  initial begin
    int n;
    dtx_t d;
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    dtx_t d;
    rst_n = 1'b0; dbg_sel = '0; spur_i = 1'b0; spur_d = 1'b0; fchk_en = 1'b0;
    imem_wait = 0; dmem_wait = 0;
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    clear_imem();
    settle();
    settle();

    // Reset state
    push(K_IREQ, 64'd0, 64'd0, "rst_imem_req");
    push(K_DREQ, 64'd0, 64'd0, "rst_dmem_req");
    push(K_HALT, 64'd0, 64'd0, "rst_halted");
    push(K_ZF, 64'd0, 64'd0, "rst_zf");
    push(K_INSTRET, 64'd0, 64'd0, "rst_instret");
    push(K_PC, 64'd0, 64'd0, "rst_pc");
    settle();
    check_reg(1, 64'd0, "rst_r1");

    // Program 1: LI/LI/SUB/JZ taken over LI r4
    put(0, ins(1, 1, 0, 0, 5));
    put(1, ins(1, 2, 0, 0, 5));
    put(2, ins(3, 3, 1, 2, 0));
    put(3, ins(11, 0, 0, 0, 6));
    put(4, ins(1, 4, 0, 0, 1));
    put(6, ins(14, 0, 0, 0, 0));
    run(200, n);
    check_prog1(n, 11, "p1_zw");

    hold_reset();
    imem_wait = 3;
    run(200, n);
    check_prog1(n, 26, "p1_w3");

    // Program 2: store then load through a 2-wait data memory
    hold_reset();
    clear_imem();
    imem_wait = 1; dmem_wait = 2;
    put(0, ins(1, 1, 0, 0, 28'h1234567));
    put(1, ins(1, 2, 0, 0, 28'h10));
    put(2, ins(13, 0, 1, 1, 0));
    put(3, ins(9, 0, 1, 2, 0));
    put(4, ins(8, 5, 0, 2, 0));
    put(5, ins(15, 0, 0, 0, 0));
    d.we = 1'b1; d.addr = 28'h10; d.wdata = 28'h1234567; dq.push_back(d);
    d.we = 1'b0; d.addr = 28'h10; d.wdata = '0;         dq.push_back(d);
    run(300, n);
    push(K_ZF, 64'd1, 64'd0, "p2_zf_kept");
    push(K_INSTRET, 64'd6, 64'd0, "p2_instret");
    push(K_VAL, 64'd0, 64'(dq.size()), "p2_dmem_done");
    settle();
    check_reg(5, 64'h1234567, "p2_r5");
    check_reg(1, 64'h1234567, "p2_r1");

    // Program 3: logic ops, 28-bit wrap, JNZ/JZ, PC wrap 0xFFF -> 0
    hold_reset();
    clear_imem();
    imem_wait = 0; dmem_wait = 0;
    put(0,  ins(11, 0, 0, 0, 28'h40));
    put(1,  ins(1, 2, 0, 0, 28'hF0F0F0F));
    put(2,  ins(1, 3, 0, 0, 28'h0FF00FF));
    put(3,  ins(4, 4, 2, 3, 0));
    put(4,  ins(5, 5, 2, 3, 0));
    put(5,  ins(6, 6, 2, 3, 0));
    put(6,  ins(2, 7, 2, 3, 0));
    put(7,  ins(3, 8, 3, 2, 0));
    put(8,  ins(1, 1, 0, 0, 28'hFFFFFFF));
    put(9,  ins(7, 1, 1, 0, 1));
    put(10, ins(12, 0, 0, 0, 28'h30));
    put(11, ins(10, 0, 0, 0, 28'hFFF));
    put(12'hFFF, ins(0, 0, 0, 0, 0));
    put(12'h40, ins(15, 0, 0, 0, 0));
    for (int i = 0; i < 12; i++) fq.push_back(12'(i));
    fq.push_back(12'hFFF); fq.push_back(12'h000); fq.push_back(12'h040);
    fchk_en = 1'b1;
    run(300, n);
    push(K_ZF, 64'd1, 64'd0, "p3_zf");
    push(K_INSTRET, 64'd15, 64'd0, "p3_instret");
    push(K_PC, 64'h40, 64'd0, "p3_pc");
    push(K_VAL, 64'd0, 64'(fq.size()), "p3_fetch_done");
    settle();
    fchk_en = 1'b0;
    check_reg(1, 64'h0, "p3_addi_wrap");
    check_reg(4, 64'h00F000F, "p3_and");
    check_reg(5, 64'hFFF0FFF, "p3_or");
    check_reg(6, 64'hFF00FF0, "p3_xor");
    check_reg(7, 64'h00E100E, "p3_add_wrap");
    check_reg(8, 64'h1EFF1F0, "p3_sub");

    // Program 4: HALT with spurious acks
    hold_reset();
    clear_imem();
    put(0, ins(15, 0, 0, 0, 0));
    run(100, n);
    spur_i = 1'b1; spur_d = 1'b1;
    repeat (5) settle();
    push(K_IREQ, 64'd0, 64'd0, "p4_imem_req");
    push(K_DREQ, 64'd0, 64'd0, "p4_dmem_req");
    push(K_HALT, 64'd1, 64'd0, "p4_halted");
    push(K_INSTRET, 64'd1, 64'd0, "p4_instret");
    push(K_PC, 64'd0, 64'd0, "p4_pc");
    settle();
    spur_i = 1'b0; spur_d = 1'b0;

    // Program 5: reset asserted mid-MEM
    hold_reset();
    clear_imem();
    dmem_wait = 20;
    put(0, ins(1, 1, 0, 0, 7));
    put(1, ins(1, 2, 0, 0, 28'h10));
    put(2, ins(9, 0, 1, 2, 0));
    put(3, ins(15, 0, 0, 0, 0));
    rst_n = 1'b1;
    n = 0;
    while (n < 100 && !dmem_req) begin
      settle();
      n++;
    end
    push(K_DREQ, 64'd1, 64'd0, "p5_mem_entered");
    settle();
    rst_n = 1'b0;
    spur_d = 1'b1;
    push(K_DREQ, 64'd0, 64'd0, "p5_dreq_drop");
    push(K_IREQ, 64'd0, 64'd0, "p5_ireq_low");
    settle();
    push(K_INSTRET, 64'd0, 64'd0, "p5_instret");
    check_reg(1, 64'd0, "p5_r1");
    check_reg(2, 64'd0, "p5_r2");
    spur_d = 1'b0;
    rst_n = 1'b1;
    push(K_IREQ, 64'd0, 64'd0, "p5_boot");
    settle();
    push(K_IREQ, 64'd1, 64'd0, "p5_fetch");
    push(K_PC, 64'd0, 64'd0, "p5_fetch_pc");
    settle();
    rst_n = 1'b0;
    settle();
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
